// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
//   Small synchronous FIFO between the instruction decoder and the dispatch
//   stage. Holds 2^AW decoded micro-instructions and presents the head entry
//   first-word fall-through. The pointers carry one extra wrap bit, so full and
//   empty can be told apart without a separate occupancy counter. Full, empty,
//   count and the head data come only from registered pointers.
//
// Ports
//   CLK                input   clock, rising edge
//   RSTn               input   asynchronous active-low reset (clears pointers)
//   instrFifo_push     input   write request from the decoder
//   decode_microInstr  input   [DW-1:0] entry to write
//   instrFifo_full     output  no free entry
//   instrFifo_pop      input   read request from dispatch
//   instrFifo_empty    output  no valid entry
//   dispat_microInstr  output  [DW-1:0] head entry, zero while empty
//   instrFifo_count    output  [AW:0] number of valid entries, 0..2^AW
//   flush              input   discard all entries, wins over push and pop
// -----------------------------------------------------------------------------
`ifndef DECODE_INFO_DW
`define DECODE_INFO_DW 32
`endif

module instr_fifo #(
    parameter int DW = `DECODE_INFO_DW,
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          instrFifo_push,
    input  logic [DW-1:0] decode_microInstr,
    output logic          instrFifo_full,
    input  logic          instrFifo_pop,
    output logic          instrFifo_empty,
    output logic [DW-1:0] dispat_microInstr,
    output logic [AW:0]   instrFifo_count,
    input  logic          flush
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] storage_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign instrFifo_empty = (wr_ptr_q == rd_ptr_q);
    // Same slot with opposite wrap bits: the writer is a full lap ahead.
    assign instrFifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                             (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign instrFifo_count = wr_ptr_q - rd_ptr_q;

    assign dispat_microInstr = instrFifo_empty ? '0 : storage_q[rd_ptr_q[AW-1:0]];

    // Flush discards the cycle's push and pop, so neither may touch state.
    assign push_ok = instrFifo_push && !instrFifo_full  && !flush;
    assign pop_ok  = instrFifo_pop  && !instrFifo_empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the empty gate on the output keeps
    // unwritten entries from ever being observed.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            storage_q[wr_ptr_q[AW-1:0]] <= decode_microInstr;
        end
    end

endmodule

// File: tb/tb_instr_fifo.sv
// -----------------------------------------------------------------------------
// tb_instr_fifo
//   Directed bench for instr_fifo (DW = 8, AW = 2). A table of vectors with
//   hand-computed expected flags, count and head data covers fill/drain,
//   overflow drop, pop on empty, push+pop at partial and full occupancy, and
//   flush priority. Hand-written sequences cover a long wrap-around run and an
//   asynchronous reset taken mid-cycle.
// -----------------------------------------------------------------------------
module tb_instr_fifo;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          CLK;
    logic          RSTn;
    logic          instrFifo_push;
    logic [DW-1:0] decode_microInstr;
    logic          instrFifo_full;
    logic          instrFifo_pop;
    logic          instrFifo_empty;
    logic [DW-1:0] dispat_microInstr;
    logic [AW:0]   instrFifo_count;
    logic          flush;

    int n_vec;
    int n_bad;

    instr_fifo #(.DW(DW), .AW(AW)) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .instrFifo_push    (instrFifo_push),
        .decode_microInstr (decode_microInstr),
        .instrFifo_full    (instrFifo_full),
        .instrFifo_pop     (instrFifo_pop),
        .instrFifo_empty   (instrFifo_empty),
        .dispat_microInstr (dispat_microInstr),
        .instrFifo_count   (instrFifo_count),
        .flush             (flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          push;
        logic          pop;
        logic          fl;
        logic [DW-1:0] data;
        logic          e_empty;
        logic          e_full;
        logic [AW:0]   e_count;
        logic [DW-1:0] e_out;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic e_empty, input logic e_full,
                         input logic [AW:0] e_count, input logic [DW-1:0] e_out);
        n_vec++;
        if (instrFifo_empty !== e_empty || instrFifo_full !== e_full ||
            instrFifo_count !== e_count || dispat_microInstr !== e_out) begin
            n_bad++;
            $display("FAIL %s: got empty=%0b full=%0b count=%0d out=%h, expected empty=%0b full=%0b count=%0d out=%h",
                     name, instrFifo_empty, instrFifo_full, instrFifo_count, dispat_microInstr,
                     e_empty, e_full, e_count, e_out);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic push, input logic pop, input logic fl, input logic [DW-1:0] data);
        @(negedge CLK);
        instrFifo_push    = push;
        instrFifo_pop     = pop;
        flush             = fl;
        decode_microInstr = data;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        RSTn              = 1'b0;
        instrFifo_push    = 1'b0;
        instrFifo_pop     = 1'b0;
        flush             = 1'b0;
        decode_microInstr = '0;

        //            push pop fl  data   empty full cnt out
        // fill and drain, overflow drop, pop on empty
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 3'd1, 8'hA1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 3'd2, 8'hA1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 3'd3, 8'hA1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hD4, 1'b0, 1'b1, 3'd4, 8'hA1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hE5, 1'b0, 1'b1, 3'd4, 8'hA1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'hB2});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'hC3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'hD4});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
        // push+pop at count 2, then push+pop while full (pointers cross wrap bit)
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 3'd1, 8'h11});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 3'd2, 8'h11});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 3'd2, 8'h22});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 3'd3, 8'h22});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 3'd4, 8'h22});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 3'd3, 8'h33});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h44});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h55});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
        // flush at count 3 with push and pop high
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h71, 1'b0, 1'b0, 3'd1, 8'h71});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h72, 1'b0, 1'b0, 3'd2, 8'h71});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h73, 1'b0, 1'b0, 3'd3, 8'h71});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h74, 1'b1, 1'b0, 3'd0, 8'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h75, 1'b0, 1'b0, 3'd1, 8'h75});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});

        #12;
        check("reset_state", 1'b1, 1'b0, 3'd0, 8'h00);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].fl, tbl[i].data);
            check($sformatf("vec%0d", i), tbl[i].e_empty, tbl[i].e_full,
                  tbl[i].e_count, tbl[i].e_out);
        end

        // Wrap-around: entries 0x40+j, ten push+pop pairs at count 2.
        step(1'b1, 1'b0, 1'b0, 8'h40);
        check("wrap_fill0", 1'b0, 1'b0, 3'd1, 8'h40);
        step(1'b1, 1'b0, 1'b0, 8'h41);
        check("wrap_fill1", 1'b0, 1'b0, 3'd2, 8'h40);
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] wv;
            logic [DW-1:0] hv;
            wv = 8'h40 + 8'(i + 2);
            hv = 8'h40 + 8'(i + 1);
            step(1'b1, 1'b1, 1'b0, wv);
            check($sformatf("wrap_pair%0d", i), 1'b0, 1'b0, 3'd2, hv);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("wrap_drain0", 1'b0, 1'b0, 3'd1, 8'h4B);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("wrap_drain1", 1'b1, 1'b0, 3'd0, 8'h00);

        // Asynchronous reset mid-cycle with two entries held.
        step(1'b1, 1'b0, 1'b0, 8'hC1);
        step(1'b1, 1'b0, 1'b0, 8'hC2);
        check("pre_reset", 1'b0, 1'b0, 3'd2, 8'hC1);
        instrFifo_push = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        check("async_reset", 1'b1, 1'b0, 3'd0, 8'h00);
        @(negedge CLK);
        RSTn = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        check("post_reset_push", 1'b0, 1'b0, 3'd1, 8'h5A);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("post_reset_pop", 1'b1, 1'b0, 3'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
